// File: rtl/sp_pkg.sv
// sp_pkg: shared constants and types for the receive-side comma aligner.
//   SYM_W      symbol width (10-bit 8b/10b code groups)
//   COMMA_RDN  K28.5 code group, running disparity negative
//   COMMA_RDP  K28.5 code group, running disparity positive
//   state_t    aligner FSM states
package sp_pkg;

  localparam int unsigned SYM_W = 10;

  localparam logic [SYM_W-1:0] COMMA_RDN = 10'h17C;
  localparam logic [SYM_W-1:0] COMMA_RDP = 10'h283;

  typedef enum logic [1:0] {
    S_HUNT   = 2'd0,
    S_SYNC   = 2'd1,
    S_LOCKED = 2'd2
  } state_t;

endpackage

// File: rtl/sp_comma_detect.sv
// sp_comma_detect: combinational K28.5 detector on a 10-bit window.
//   W      candidate 10-bit window, bit 0 = earliest received bit
//   match  high when W is K28.5 of either running disparity
module sp_comma_detect
  import sp_pkg::*;
(
  input  logic [SYM_W-1:0] W,
  output logic             match
);

  always_comb begin
    match = (W == COMMA_RDN) || (W == COMMA_RDP);
  end

endmodule

// File: rtl/sp_comma_aligner.sv
// sp_comma_aligner: serial-to-parallel converter with K28.5 comma alignment.
// Accepts an LSB-first bit stream, finds 10-bit symbol boundaries from
// K28.5 commas and emits aligned symbols with a one-cycle strobe.
//   CLOCK    bit clock, all state changes on posedge
//   RESET_L  asynchronous active-low reset
//   IS       serial data in, bit a first
//   OP       aligned symbol, bit 0 = first received bit
//   VALID    one-cycle strobe, OP holds a new symbol
//   K        qualifies VALID, high when OP is K28.5
//   LOCKED   high while the FSM is in LOCKED
//   ERR_CNT  saturating misaligned-comma count (only with ALIGN_ERRCNT_EN)
// Parameters:
//   LOCK_COMMAS  aligned commas (counting the first) needed to lock, 1..15
//   LOSS_LIMIT   consecutive misaligned commas in LOCKED that force HUNT, 1..15
// Build option: define ALIGN_ERRCNT_EN to add the ERR_CNT port and counter.
module sp_comma_aligner
  import sp_pkg::*;
#(
  parameter int unsigned LOCK_COMMAS = 3,
  parameter int unsigned LOSS_LIMIT  = 2
) (
  input  logic             CLOCK,
  input  logic             RESET_L,
  input  logic             IS,
  output logic [SYM_W-1:0] OP,
  output logic             VALID,
  output logic             K,
  output logic             LOCKED
`ifdef ALIGN_ERRCNT_EN
  ,
  output logic [7:0]       ERR_CNT
`endif
);

  localparam logic [3:0] LOCK_N = 4'(LOCK_COMMAS);
  localparam logic [3:0] LOSS_N = 4'(LOSS_LIMIT);

  state_t           state;
  state_t           next_state;
  // The oldest window bit is never needed again, so only 9 bits of
  // history are kept; the window is completed by the incoming bit.
  logic [SYM_W-2:0] sr;
  logic [SYM_W-1:0] win;
  logic             match;
  logic [3:0]       cnt;
  logic [3:0]       cc;
  logic [3:0]       ec;
  logic             boundary;
  logic             emit;
  logic             realign;
  logic             cc_load;
  logic             cc_inc;
  logic             ec_inc;
  logic             ec_clr;

  assign win      = {IS, sr};
  assign boundary = (cnt == 4'd9);

  sp_comma_detect u_detect (
    .W     (win),
    .match (match)
  );

  always_ff @(posedge CLOCK or negedge RESET_L) begin
    if (!RESET_L) begin
      state <= S_HUNT;
    end else begin
      state <= next_state;
    end
  end

  always_comb begin
    next_state = state;
    emit       = 1'b0;
    realign    = 1'b0;
    cc_load    = 1'b0;
    cc_inc     = 1'b0;
    ec_inc     = 1'b0;
    ec_clr     = 1'b0;
    unique case (state)
      S_HUNT: begin
        if (match) begin
          emit       = 1'b1;
          realign    = 1'b1;
          cc_load    = 1'b1;
          next_state = (LOCK_N == 4'd1) ? S_LOCKED : S_SYNC;
        end
      end
      S_SYNC: begin
        if (boundary) begin
          emit = 1'b1;
          if (match) begin
            cc_inc = 1'b1;
            if (cc + 4'd1 == LOCK_N) next_state = S_LOCKED;
          end
        end else if (match) begin
          emit    = 1'b1;
          realign = 1'b1;
          cc_load = 1'b1;
          if (LOCK_N == 4'd1) next_state = S_LOCKED;
        end
      end
      S_LOCKED: begin
        if (boundary) begin
          emit   = 1'b1;
          ec_clr = match;
        end else if (match) begin
          ec_inc = 1'b1;
          if (ec + 4'd1 == LOSS_N) next_state = S_HUNT;
        end
      end
      default: next_state = S_HUNT;
    endcase
  end

  always_comb begin
    LOCKED = (state == S_LOCKED);
  end

  always_ff @(posedge CLOCK or negedge RESET_L) begin
    if (!RESET_L) begin
      sr    <= '0;
      OP    <= '0;
      VALID <= 1'b0;
      K     <= 1'b0;
      cnt   <= '0;
      cc    <= '0;
      ec    <= '0;
    end else begin
      sr    <= win[SYM_W-1:1];
      VALID <= emit;
      K     <= emit & match;
      if (emit) OP <= win;
      if (realign || boundary) cnt <= '0;
      else                     cnt <= cnt + 4'd1;
      if (cc_load)     cc <= 4'd1;
      else if (cc_inc) cc <= cc + 4'd1;
      // EC only has meaning inside LOCKED; it restarts from zero on every entry.
      if (next_state != S_LOCKED || ec_clr) ec <= '0;
      else if (ec_inc)                      ec <= ec + 4'd1;
    end
  end

`ifdef ALIGN_ERRCNT_EN
  logic misalign;
  assign misalign = match && !boundary && (state != S_HUNT);

  always_ff @(posedge CLOCK or negedge RESET_L) begin
    if (!RESET_L) begin
      ERR_CNT <= '0;
    end else if (misalign && (ERR_CNT != 8'hFF)) begin
      ERR_CNT <= ERR_CNT + 8'd1;
    end
  end
`endif

endmodule
